// File: rtl/instr_fetch_decode_if.sv
// Memory read port of the fetch front end: req/ack handshake plus address and data.
interface instr_fetch_decode_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/instr_fetch_decode.sv
// Instruction fetch front end: IR/PC/NZCV registers, a req/ack fetch FSM,
// and the family / condition-pass decode that feeds the microsequencer.
module instr_fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fetch,
    instr_fetch_decode_if.master         mem,
    input  logic                         pc_load,
    input  logic [31:0]                  pc_in,
    input  logic                         flag_we,
    input  logic [3:0]                   flag_in,
    output logic [31:0]                  ir,
    output logic                         ir_valid,
    output logic [31:0]                  pc_out,
    output logic [3:0]                   flags,
    output logic [15:0]                  family_bits,
    output logic                         COND
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;
    logic   req;
    logic   ir_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        req      = 1'b0;
        ir_valid = 1'b0;
        ir_load  = 1'b0;
        case (state)
            IDLE: begin
                if (fetch) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                req = 1'b1;
                if (mem.mem_ack) begin
                    ir_load  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                ir_valid = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign mem.mem_req  = req;
    assign mem.mem_addr = pc_out;

    // A branch/writeback load wins over the post-fetch increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir     <= '0;
            pc_out <= RESET_PC;
            flags  <= '0;
        end else begin
            if (ir_load) begin
                ir <= mem.mem_rdata;
            end
            if (pc_load) begin
                pc_out <= pc_in;
            end else if (ir_load) begin
                pc_out <= pc_out + 32'(PC_STEP);
            end
            if (flag_we) begin
                flags <= flag_in;
            end
        end
    end

    logic n_f;
    logic z_f;
    logic c_f;
    logic v_f;

    assign {n_f, z_f, c_f, v_f} = flags;

    always_comb begin
        COND = 1'b0;
        unique case (ir[31:28])
            4'h0: COND = z_f;
            4'h1: COND = !z_f;
            4'h2: COND = c_f;
            4'h3: COND = !c_f;
            4'h4: COND = n_f;
            4'h5: COND = !n_f;
            4'h6: COND = v_f;
            4'h7: COND = !v_f;
            4'h8: COND = c_f && !z_f;
            4'h9: COND = !c_f || z_f;
            4'hA: COND = (n_f == v_f);
            4'hB: COND = (n_f != v_f);
            4'hC: COND = !z_f && (n_f == v_f);
            4'hD: COND = z_f || (n_f != v_f);
            4'hE: COND = 1'b1;
            4'hF: COND = 1'b0;
        endcase
    end

    // First matching rule wins, so the chain order is significant.
    always_comb begin
        family_bits = '0;
        if (ir[27:24] == 4'b1111) begin
            family_bits[15] = 1'b1;
        end else if (ir[27:26] == 2'b11) begin
            family_bits[14] = 1'b1;
        end else if (ir[27:25] == 3'b101) begin
            family_bits[13] = 1'b1;
        end else if (ir[27:25] == 3'b100) begin
            family_bits[12] = 1'b1;
        end else if (ir[27:25] == 3'b011 && ir[4]) begin
            family_bits[11] = 1'b1;
        end else if (ir[27:25] == 3'b011) begin
            family_bits[10] = 1'b1;
        end else if (ir[27:25] == 3'b010) begin
            family_bits[9] = 1'b1;
        end else if (ir[27:23] == 5'b00110 && ir[21:20] == 2'b10) begin
            family_bits[8] = 1'b1;
        end else if (ir[27:25] == 3'b001) begin
            family_bits[7] = 1'b1;
        end else if (ir[24:23] == 2'b10 && ir[21:20] == 2'b00
                     && ir[11:4] == 8'b0000_1001) begin
            family_bits[4] = 1'b1;
        end else if (ir[24:23] == 2'b01 && ir[7:4] == 4'b1001) begin
            family_bits[3] = 1'b1;
        end else if (ir[24:22] == 3'b000 && ir[7:4] == 4'b1001) begin
            family_bits[2] = 1'b1;
        end else if (ir[7] && ir[4]) begin
            family_bits[5] = 1'b1;
        end else if (ir[24:23] == 2'b10 && !ir[20]) begin
            family_bits[6] = 1'b1;
        end else if (ir[4]) begin
            family_bits[1] = 1'b1;
        end else begin
            family_bits[0] = 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: a transaction-level model checked
// every cycle, plus literal expectations from hand-decoded instruction words.
module tb_instr_fetch_decode;

    logic        clk;
    logic        rst_n;
    logic        fetch;
    logic        pc_load;
    logic [31:0] pc_in;
    logic        flag_we;
    logic [3:0]  flag_in;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] pc_out;
    logic [3:0]  flags;
    logic [15:0] family_bits;
    logic        COND;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_decode_if mem ();

    instr_fetch_decode #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch      (fetch),
        .mem        (mem.master),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .flag_we    (flag_we),
        .flag_in    (flag_in),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .pc_out     (pc_out),
        .flags      (flags),
        .family_bits(family_bits),
        .COND       (COND)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Family rules as (mask, value, bit) in priority order; no match -> bit 0.
    localparam logic [31:0] FMASK [15] = '{
        32'h0F00_0000, 32'h0C00_0000, 32'h0E00_0000, 32'h0E00_0000,
        32'h0E00_0010, 32'h0E00_0000, 32'h0E00_0000, 32'h0FB0_0000,
        32'h0E00_0000, 32'h0FB0_0FF0, 32'h0F80_00F0, 32'h0FC0_00F0,
        32'h0E00_0090, 32'h0F90_0000, 32'h0E00_0010};
    localparam logic [31:0] FVAL [15] = '{
        32'h0F00_0000, 32'h0C00_0000, 32'h0A00_0000, 32'h0800_0000,
        32'h0600_0010, 32'h0600_0000, 32'h0400_0000, 32'h0320_0000,
        32'h0200_0000, 32'h0100_0090, 32'h0080_0090, 32'h0000_0090,
        32'h0000_0090, 32'h0100_0000, 32'h0000_0010};
    localparam int FBIT [15] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 4, 3, 2, 5, 6, 1};

    function automatic logic [15:0] fam_model(input logic [31:0] w);
        for (int i = 0; i < 15; i++) begin
            if ((w & FMASK[i]) == FVAL[i]) return 16'(1) << FBIT[i];
        end
        return 16'h0001;
    endfunction

    // Even codes test a predicate, odd codes its negation; E always, F never.
    function automatic logic cond_model(input logic [3:0] code, input logic [3:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic p;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (code[3:1])
            3'd0: p = z;
            3'd1: p = c;
            3'd2: p = n;
            3'd3: p = v;
            3'd4: p = c & ~z;
            3'd5: p = (n == v);
            3'd6: p = ~z & (n == v);
            default: return (code == 4'hE);
        endcase
        return code[0] ? ~p : p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference state.
    logic        m_busy;
    logic        m_valid;
    logic [31:0] m_ir;
    logic [31:0] m_pc;
    logic [3:0]  m_flags;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_ir    <= '0;
            m_pc    <= '0;
            m_flags <= '0;
        end else begin
            m_valid <= m_busy && mem.mem_ack;
            if (m_busy && mem.mem_ack) begin
                m_ir   <= mem.mem_rdata;
                m_busy <= 1'b0;
            end else if (fetch && !m_busy && !m_valid) begin
                m_busy <= 1'b1;
            end
            if (pc_load) m_pc <= pc_in;
            else if (m_busy && mem.mem_ack) m_pc <= m_pc + 32'd4;
            if (flag_we) m_flags <= flag_in;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mem_req", 32'(mem.mem_req), 32'(m_busy));
            if (m_busy) chk("mem_addr", mem.mem_addr, m_pc);
            chk("ir_valid", 32'(ir_valid), 32'(m_valid));
            chk("ir", ir, m_ir);
            chk("pc_out", pc_out, m_pc);
            chk("flags", 32'(flags), 32'(m_flags));
            chk("family", 32'(family_bits), 32'(fam_model(m_ir)));
            chk("cond", 32'(COND), 32'(cond_model(m_ir[31:28], m_flags)));
        end
    end

    // All driver tasks start and end at 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_word(input logic [31:0] w, input int delay);
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        chk("req_high", 32'(mem.mem_req), 32'd1);
        repeat (delay) tick();
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = w;
        tick();
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = $urandom;
        chk("valid_pulse", 32'(ir_valid), 32'd1);
        tick();
        chk("valid_end", 32'(ir_valid), 32'd0);
    endtask

    task automatic set_flags(input logic [3:0] f);
        flag_we = 1'b1;
        flag_in = f;
        tick();
        flag_we = 1'b0;
    endtask

    localparam logic [31:0] FAM_W [6] = '{
        32'hE000_0091, 32'hE080_0091, 32'hE100_0091,
        32'hE1D0_00B0, 32'hEF00_0000, 32'hE600_0010};
    localparam logic [15:0] FAM_E [6] = '{
        16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h8000, 16'h0800};

    initial begin
        rst_n         = 1'b0;
        fetch         = 1'b0;
        pc_load       = 1'b0;
        pc_in         = '0;
        flag_we       = 1'b0;
        flag_in       = '0;
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = '0;
        repeat (2) tick();
        chk("rst_ir", ir, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_req", 32'(mem.mem_req), 32'h0);
        chk("rst_valid", 32'(ir_valid), 32'h0);
        chk("rst_family", 32'(family_bits), 32'h0001);
        chk("rst_cond", 32'(COND), 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic fetch with a two-cycle ack delay.
        chk("addr0", mem.mem_addr, 32'h0);
        fetch_word(32'hE3A0_1005, 2);
        chk("t1_ir", ir, 32'hE3A0_1005);
        chk("t1_pc", pc_out, 32'h4);
        chk("t1_family", 32'(family_bits), 32'h0080);
        chk("t1_cond", 32'(COND), 32'h1);

        // Branch with EQ, before and after a Z flag write.
        fetch_word(32'h0A00_0010, 0);
        chk("t2_family", 32'(family_bits), 32'h2000);
        chk("t2_cond_pre", 32'(COND), 32'h0);
        set_flags(4'b0100);
        chk("t2_cond_post", 32'(COND), 32'h1);

        // Family literals, also pinning the table model.
        for (int i = 0; i < 6; i++) begin
            fetch_word(FAM_W[i], i % 2);
            chk("fam_lit", 32'(family_bits), 32'(FAM_E[i]));
            chk("fam_model", 32'(fam_model(FAM_W[i])), 32'(FAM_E[i]));
        end

        // Condition sweep: every code against every NZCV value.
        for (int code = 0; code < 16; code++) begin
            fetch_word({4'(code), 28'h3A0_1005}, 0);
            for (int f = 0; f < 16; f++) begin
                set_flags(4'(f));
                if (code == 15) chk("cond_never", 32'(COND), 32'h0);
            end
        end
        chk("pin_hi", 32'(cond_model(4'h8, 4'b0010)), 32'h1);
        chk("pin_ls", 32'(cond_model(4'h9, 4'b0010)), 32'h0);
        chk("pin_lt", 32'(cond_model(4'hB, 4'b1000)), 32'h1);
        chk("pin_le", 32'(cond_model(4'hD, 4'b0000)), 32'h0);

        // Stray ack while idle must not touch the IR.
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem.mem_ack = 1'b0;
        tick();
        chk("stray_ack_ir", ir, 32'hF3A0_1005);

        // pc_load coincident with the ack wins over the increment.
        fetch = 1'b1;
        tick();
        fetch         = 1'b0;
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = 32'hE1A0_0000;
        pc_load       = 1'b1;
        pc_in         = 32'h0000_0100;
        tick();
        mem.mem_ack = 1'b0;
        pc_load     = 1'b0;
        tick();
        chk("ld_pc", pc_out, 32'h0000_0100);
        chk("ld_ir", ir, 32'hE1A0_0000);

        // pc_load during REQ redirects the address before the ack.
        fetch = 1'b1;
        tick();
        fetch   = 1'b0;
        pc_load = 1'b1;
        pc_in   = 32'h0000_0200;
        tick();
        pc_load = 1'b0;
        chk("redir_addr", mem.mem_addr, 32'h0000_0200);
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = 32'hE080_0091;
        tick();
        mem.mem_ack = 1'b0;
        tick();
        chk("redir_pc", pc_out, 32'h0000_0204);

        // Reset mid-REQ abandons the transaction; the late ack is ignored.
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        chk("mid_req", 32'(mem.mem_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_drop_req", 32'(mem.mem_req), 32'h0);
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = 32'hDEAD_BEEF;
        tick();
        rst_n = 1'b1;
        tick();
        mem.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_valid", 32'(ir_valid), 32'h0);
            chk("post_rst_ir", ir, 32'h0);
            chk("post_rst_pc", pc_out, 32'h0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
